seg_scan_decoder: RTL and testbench

Receive-side decoder for the multiplexed seven-segment display bus driven by the cycle-computer core. It watches SegA–SegG, DP and the active-low digit selects nDigit. It settles on each scanned digit, decodes the segment pattern back to a 4-bit code, and assembles complete 4-digit frames. A frame is published only after it repeats unchanged, so it can serve as a self-check monitor or feed a secondary display or logger.

---
 rtl/seg_scan_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus: settles on each select,
// decodes segments to digit codes and publishes frames once they repeat. Optional DP_CAPTURE_EN.
module seg_scan_decoder #(
  parameter int SETTLE        = 2,
  parameter int STABLE_FRAMES = 2,
  parameter int SCAN_TIMEOUT  = 4096
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       SegA,
  input  logic       SegB,
  input  logic       SegC,
  input  logic       SegD,
  input  logic       SegE,
  input  logic       SegF,
  input  logic       SegG,
  input  logic       DP,
  input  logic [3:0] nDigit,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] dp,
  output logic       frame_valid,
  output logic       scan_err,
  output logic       scan_lost
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(SCAN_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
  localparam logic [MW-1:0] MATCH_V  = MW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TMO_V    = TW'(SCAN_TIMEOUT);

  logic [6:0]    r_seg;
  logic [3:0]    r_ndig;
  logic [3:0]    r_ndig_q;
  logic [SW-1:0] r_settle;
  logic [MW-1:0] r_match;
  logic [TW-1:0] r_tmo;
  logic [3:0]    r_mask;
  logic [15:0]   r_work;
  logic [15:0]   r_prev;
  logic [15:0]   r_out;

  logic          w_onehot;
  logic          w_blank;
  logic          w_illegal;
  logic [1:0]    w_idx;
  logic [3:0]    w_code;
  logic [SW-1:0] w_settle_nxt;
  logic          w_capture;
  logic [15:0]   w_frame;
  logic [3:0]    w_bit;
  logic          w_complete;
  logic          w_equal;
  logic [MW-1:0] w_match_nxt;
  logic          w_publish;
  logic          w_tmo_hit;

  // Every pin is registered once; all logic below sees only the registered copies.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_seg    <= '0;
      r_ndig   <= 4'hF;
      r_ndig_q <= 4'hF;
    end else begin
      r_seg    <= {SegG, SegF, SegE, SegD, SegC, SegB, SegA};
      r_ndig   <= nDigit;
      r_ndig_q <= r_ndig;
    end
  end

  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_ndig)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  assign w_blank   = (r_ndig == 4'hF);
  assign w_illegal = !w_onehot && !w_blank;
  assign w_bit     = 4'b0001 << w_idx;

  // Segment vector is {G,F,E,D,C,B,A}.
  always_comb begin
    w_code = 4'hE;
    case (r_seg)
      7'h3F: w_code = 4'h0;
      7'h06: w_code = 4'h1;
      7'h5B: w_code = 4'h2;
      7'h4F: w_code = 4'h3;
      7'h66: w_code = 4'h4;
      7'h6D: w_code = 4'h5;
      7'h7D: w_code = 4'h6;
      7'h07: w_code = 4'h7;
      7'h7F: w_code = 4'h8;
      7'h6F: w_code = 4'h9;
      7'h00: w_code = 4'hF;
      default: w_code = 4'hE;
    endcase
  end

  always_comb begin
    w_settle_nxt = r_settle;
    if (!w_onehot)
      w_settle_nxt = '0;
    else if (r_ndig != r_ndig_q)
      w_settle_nxt = SW'(1);
    else if (r_settle != SETTLE_V)
      w_settle_nxt = r_settle + 1'b1;
  end

  // A new select always counts as a fresh dwell, even when SETTLE is 1 and the counter is already full.
  assign w_capture = w_onehot && (w_settle_nxt == SETTLE_V) &&
                     ((r_ndig != r_ndig_q) || (r_settle != SETTLE_V));

  always_comb begin
    w_frame = r_work;
    w_frame[{w_idx, 2'b00} +: 4] = w_code;
  end

`ifdef DP_CAPTURE_EN
  logic       r_dp;
  logic [3:0] r_work_dp;
  logic [3:0] r_prev_dp;
  logic [3:0] r_out_dp;
  logic [3:0] w_frame_dp;

  always_comb begin
    w_frame_dp        = r_work_dp;
    w_frame_dp[w_idx] = r_dp;
  end

  assign w_equal = (w_frame == r_prev) && (w_frame_dp == r_prev_dp);
  assign dp      = r_out_dp;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_dp      <= 1'b0;
      r_work_dp <= '0;
      r_prev_dp <= '0;
      r_out_dp  <= '0;
    end else begin
      r_dp <= DP;
      if (w_capture) r_work_dp <= w_frame_dp;
      if (w_complete) r_prev_dp <= w_frame_dp;
      if (w_publish) r_out_dp <= w_frame_dp;
    end
  end
`else
  logic w_unused_dp;
  assign w_unused_dp = DP;
  assign w_equal     = (w_frame == r_prev);
  assign dp          = 4'b0000;
`endif

  assign w_complete = w_capture && ((r_mask | w_bit) == 4'hF);
  assign w_tmo_hit  = !w_capture && (r_tmo == TMO_V - 1'b1);

  always_comb begin
    if (w_equal)
      w_match_nxt = (r_match == MATCH_V) ? r_match : r_match + 1'b1;
    else
      w_match_nxt = MW'(1);
  end

  assign w_publish = w_complete && (w_match_nxt >= MATCH_V);

  // frame_valid is a one-cycle strobe with no back-pressure: digit3..0/dp are valid in that
  // cycle and stay unchanged until the next strobe.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_settle    <= '0;
      r_match     <= '0;
      r_tmo       <= '0;
      r_mask      <= '0;
      r_work      <= 16'hFFFF;
      r_prev      <= 16'hFFFF;
      r_out       <= 16'hFFFF;
      frame_valid <= 1'b0;
      scan_err    <= 1'b0;
      scan_lost   <= 1'b0;
    end else begin
      r_settle    <= w_settle_nxt;
      frame_valid <= w_publish;
      scan_err    <= w_illegal;

      if (w_capture)
        r_tmo <= '0;
      else if (r_tmo != TMO_V)
        r_tmo <= r_tmo + 1'b1;

      if (w_illegal) begin
        r_mask  <= '0;
        r_match <= '0;
      end else if (w_capture) begin
        r_work <= w_frame;
        if (w_complete) begin
          r_mask  <= '0;
          r_match <= w_match_nxt;
          r_prev  <= w_frame;
        end else begin
          r_mask <= r_mask | w_bit;
        end
      end else if (w_tmo_hit) begin
        r_mask  <= '0;
        r_match <= '0;
      end

      if (w_publish) begin
        r_out     <= w_frame;
        scan_lost <= 1'b0;
      end else if (w_tmo_hit) begin
        scan_lost <= 1'b1;
      end
    end
  end

  assign digit3 = r_out[15:12];
  assign digit2 = r_out[11:8];
  assign digit1 = r_out[7:4];
  assign digit0 = r_out[3:0];

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a driver scans whole frames onto the bus, and a monitor
// pops expected {dp, digit3..digit0} words from a queue on every frame_valid strobe.
module tb_seg_scan_decoder;

  logic       Clock;
  logic       nReset;
  logic       SegA, SegB, SegC, SegD, SegE, SegF, SegG;
  logic       DP;
  logic [3:0] nDigit;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [3:0] dp;
  logic       frame_valid;
  logic       scan_err;
  logic       scan_lost;

  int total = 0;
  int bad   = 0;
  int err_pulses = 0;
  logic [19:0] exp_q[$];

`ifdef DP_CAPTURE_EN
  localparam logic [3:0] DP_125 = 4'b0010;
`else
  localparam logic [3:0] DP_125 = 4'b0000;
`endif

  seg_scan_decoder dut (
    .Clock(Clock), .nReset(nReset),
    .SegA(SegA), .SegB(SegB), .SegC(SegC), .SegD(SegD),
    .SegE(SegE), .SegF(SegF), .SegG(SegG), .DP(DP),
    .nDigit(nDigit),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .dp(dp), .frame_valid(frame_valid), .scan_err(scan_err), .scan_lost(scan_lost)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // forward encoder; 4'hE drives the invalid pattern A,B,G
  function automatic logic [6:0] seg_of(input logic [3:0] code);
    case (code)
      4'h0: seg_of = 7'h3F;
      4'h1: seg_of = 7'h06;
      4'h2: seg_of = 7'h5B;
      4'h3: seg_of = 7'h4F;
      4'h4: seg_of = 7'h66;
      4'h5: seg_of = 7'h6D;
      4'h6: seg_of = 7'h7D;
      4'h7: seg_of = 7'h07;
      4'h8: seg_of = 7'h7F;
      4'h9: seg_of = 7'h6F;
      4'hE: seg_of = 7'h43;
      default: seg_of = 7'h00;
    endcase
  endfunction

  // driver tasks (called at a falling edge)
  task automatic drive_digit(input int idx, input logic [3:0] code, input logic dpv, input int dwell);
    logic [3:0] sel;
    sel = 4'b0001 << idx;
    nDigit = ~sel;
    {SegG, SegF, SegE, SegD, SegC, SegB, SegA} = seg_of(code);
    DP = dpv;
    repeat (dwell) @(negedge Clock);
  endtask

  task automatic scan_frame(input logic [15:0] codes, input logic [3:0] dps);
    for (int i = 3; i >= 0; i--) drive_digit(i, codes[4*i +: 4], dps[i], 8);
  endtask

  task automatic gap(input int n);
    nDigit = 4'hF;
    {SegG, SegF, SegE, SegD, SegC, SegB, SegA} = 7'h00;
    DP = 1'b0;
    repeat (n) @(negedge Clock);
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge Clock);
      waited++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge Clock) begin
    if (nReset && scan_err) err_pulses++;
    if (nReset && frame_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_publish: got %h expected none", {dp, digit3, digit2, digit1, digit0});
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({dp, digit3, digit2, digit1, digit0} !== e) begin
          bad++;
          $display("FAIL publish: got %h expected %h", {dp, digit3, digit2, digit1, digit0}, e);
        end
      end
    end
  end

  initial begin
    nReset = 1'b0;
    nDigit = 4'hF;
    {SegG, SegF, SegE, SegD, SegC, SegB, SegA} = 7'h00;
    DP = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_digits", {digit3, digit2, digit1, digit0}, 16'hFFFF);
    check("reset_dp", dp, 4'h0);
    check("reset_fv", frame_valid, 1'b0);
    check("reset_err", scan_err, 1'b0);
    check("reset_lost", scan_lost, 1'b0);
    nReset = 1'b1;
    gap(4);

    // "0123": first frame only primes the match counter
    scan_frame(16'h0123, 4'b0000);
    check("no_publish_frame1", {digit3, digit2, digit1, digit0}, 16'hFFFF);
    exp_q.push_back({4'b0000, 16'h0123});
    scan_frame(16'h0123, 4'b0000);
    gap(6);
    drain("publish_0123");

    // "12.5" with decimal point on digit1
    scan_frame(16'hF125, 4'b0010);
    exp_q.push_back({DP_125, 16'hF125});
    scan_frame(16'hF125, 4'b0010);
    gap(6);
    drain("publish_12p5");

    // reset mid-frame discards partial state
    drive_digit(3, 4'h9, 1'b0, 8);
    drive_digit(2, 4'h9, 1'b0, 4);
    nReset = 1'b0;
    @(negedge Clock);
    check("midreset_digits", {digit3, digit2, digit1, digit0}, 16'hFFFF);
    nReset = 1'b1;
    gap(4);

    // alternating frames never qualify
    for (int k = 0; k < 3; k++) begin
      scan_frame(16'h0100, 4'b0000);
      scan_frame(16'h0101, 4'b0000);
    end
    gap(6);
    check("alt_outputs_blank", {digit3, digit2, digit1, digit0}, 16'hFFFF);

    // illegal select mid-frame: match count cleared, so "0101" needs two more frames
    drive_digit(3, 4'h0, 1'b0, 8);
    drive_digit(2, 4'h1, 1'b0, 8);
    nDigit = 4'b0011;
    @(negedge Clock);
    gap(4);
    check("scan_err_pulses", err_pulses, 1);
    scan_frame(16'h0101, 4'b0000);
    gap(6);
    check("no_publish_after_err", {digit3, digit2, digit1, digit0}, 16'hFFFF);
    exp_q.push_back({4'b0000, 16'h0101});
    scan_frame(16'h0101, 4'b0000);
    gap(6);
    drain("publish_after_err");

    // invalid pattern on digit2, blank digit3
    scan_frame(16'hFE34, 4'b0000);
    exp_q.push_back({4'b0000, 16'hFE34});
    scan_frame(16'hFE34, 4'b0000);
    gap(6);
    drain("publish_invalid_blank");

    // scan loss after a long blanking gap
    gap(3990);
    check("lost_before_timeout", scan_lost, 1'b0);
    gap(200);
    check("lost_after_timeout", scan_lost, 1'b1);
    check("held_after_timeout", {digit3, digit2, digit1, digit0}, 16'hFE34);
    scan_frame(16'h2468, 4'b0000);
    check("lost_still_high", scan_lost, 1'b1);
    exp_q.push_back({4'b0000, 16'h2468});
    scan_frame(16'h2468, 4'b0000);
    gap(6);
    drain("publish_after_lost");
    check("lost_cleared", scan_lost, 1'b0);
    check("total_err_pulses", err_pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
